// File: rtl/renesas_i2c_regs_q.sv
// Host register bank for the I2C clock-configuration engine: headers, status/event capture, control, command FIFO.
// Reads are combinational from the address; writes, events and FIFO updates land on the next rising edge.
module renesas_i2c_regs_q #(
    parameter int NUM_HDR    = 4,
    parameter int STAT_W     = 8,
    parameter int CMD_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    sys_if_clk,
    input  logic                    sys_if_rst,
    input  logic                    sys_if_wen,
    input  logic [31:0]             sys_if_addr,
    input  logic [31:0]             sys_if_wdata,
    output logic [31:0]             sys_if_rdata,
    input  logic [32*NUM_HDR-1:0]   IO_HEADER_VALUE,
    input  logic [STAT_W-1:0]       IO_STATUS_VALUE,
    output logic                    IO_CONTROL_RESETN,
    output logic                    IO_CONTROL_START,
    output logic [CMD_W-1:0]        cmd_tdata,
    output logic                    cmd_tvalid,
    input  logic                    cmd_tready,
    output logic                    irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    localparam logic [31:0] A_CONTROL = 32'h00;
    localparam logic [31:0] A_STATUS  = 32'h04;
    localparam logic [31:0] A_EVENT   = 32'h08;
    localparam logic [31:0] A_IRQ_EN  = 32'h0C;
    localparam logic [31:0] A_CMD     = 32'h10;
    localparam logic [31:0] A_FIFO    = 32'h14;
    localparam logic [31:0] A_HDR     = 32'h40;

    logic              ctrl_resetn, start_q, irq_q;
    logic [STAT_W:0]   event_q, irq_en_q, ev_set, ev_clr;
    logic [STAT_W-1:0] stat_hist;
    logic [CMD_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              wr_ctrl, wr_event, wr_irq_en, wr_cmd;
    logic              resetn_next, push, pop, full, empty, push_ok, ovf;

    assign wr_ctrl   = sys_if_wen && (sys_if_addr == A_CONTROL);
    assign wr_event  = sys_if_wen && (sys_if_addr == A_EVENT);
    assign wr_irq_en = sys_if_wen && (sys_if_addr == A_IRQ_EN);
    assign wr_cmd    = sys_if_wen && (sys_if_addr == A_CMD);

    // Flush keys off the next RESETN value so a 1->0 write empties the FIFO on the same edge.
    assign resetn_next = wr_ctrl ? sys_if_wdata[0] : ctrl_resetn;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign pop     = cmd_tvalid && cmd_tready;
    assign push    = wr_cmd && ctrl_resetn;
    assign push_ok = push && (!full || pop);
    assign ovf     = push && full && !pop;

    assign ev_set = {ovf, IO_STATUS_VALUE & ~stat_hist};
    assign ev_clr = wr_event ? sys_if_wdata[STAT_W:0] : '0;

    assign IO_CONTROL_RESETN = ctrl_resetn;
    assign IO_CONTROL_START  = start_q;
    assign irq               = irq_q;
    assign cmd_tvalid        = !empty;
    assign cmd_tdata         = mem[rd_ptr];

    always_ff @(posedge sys_if_clk or posedge sys_if_rst) begin
        if (sys_if_rst) begin
            ctrl_resetn <= 1'b0;
            start_q     <= 1'b0;
            irq_en_q    <= '0;
            event_q     <= '0;
            stat_hist   <= '0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_resetn <= resetn_next;
            start_q     <= wr_ctrl && sys_if_wdata[1];
            if (wr_irq_en)
                irq_en_q <= sys_if_wdata[STAT_W:0];
            // Set has priority over a same-cycle W1C clear.
            event_q     <= (event_q & ~ev_clr) | ev_set;
            stat_hist   <= IO_STATUS_VALUE;
            irq_q       <= |(event_q & irq_en_q);
        end
    end

    always_ff @(posedge sys_if_clk or posedge sys_if_rst) begin
        if (sys_if_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (!resetn_next) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                level <= level + LW'(1);
            else if (pop && !push_ok)
                level <= level - LW'(1);
        end
    end

    always_ff @(posedge sys_if_clk) begin
        if (push_ok)
            mem[wr_ptr] <= sys_if_wdata[CMD_W-1:0];
    end

    always_comb begin
        sys_if_rdata = '0;
        case (sys_if_addr)
            A_CONTROL: sys_if_rdata = {31'b0, ctrl_resetn};
            A_STATUS:  sys_if_rdata = 32'(IO_STATUS_VALUE);
            A_EVENT:   sys_if_rdata = 32'(event_q);
            A_IRQ_EN:  sys_if_rdata = 32'(irq_en_q);
            A_FIFO:    sys_if_rdata = {14'b0, full, empty, 16'(level)};
            default:   sys_if_rdata = '0;
        endcase
        for (int i = 0; i < NUM_HDR; i++) begin
            if (sys_if_addr == A_HDR + 32'(4 * i))
                sys_if_rdata = IO_HEADER_VALUE[32*i +: 32];
        end
    end
endmodule

// File: tb/tb_renesas_i2c_regs_q.sv
// Directed bench for renesas_i2c_regs_q: register map, W1C events, irq timing, FIFO ordering/overflow, flush, async reset.
module tb_renesas_i2c_regs_q;
    logic         clk = 1'b0;
    logic         rst;
    logic         wen;
    logic [31:0]  addr, wdata, rdata;
    logic [127:0] hdr;
    logic [7:0]   status;
    logic         resetn_o, start_o, tvalid, tready, irq;
    logic [31:0]  tdata;
    int           n_assert = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    renesas_i2c_regs_q dut (
        .sys_if_clk(clk), .sys_if_rst(rst), .sys_if_wen(wen), .sys_if_addr(addr),
        .sys_if_wdata(wdata), .sys_if_rdata(rdata), .IO_HEADER_VALUE(hdr),
        .IO_STATUS_VALUE(status), .IO_CONTROL_RESETN(resetn_o), .IO_CONTROL_START(start_o),
        .cmd_tdata(tdata), .cmd_tvalid(tvalid), .cmd_tready(tready), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    // Drives one write in the low phase; returns at the falling edge after it took effect.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wen = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_seq [8];
        hdr = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        rst = 1'b1; wen = 1'b0; addr = 32'h0; wdata = 32'h0; status = 8'h00; tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_resetn", 32'(resetn_o), 32'h0);
        chk("rst_start", 32'(start_o), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_tvalid", 32'(tvalid), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        rd(32'h00, 32'h0, "rd_control");
        rd(32'h08, 32'h0, "rd_event");
        rd(32'h0C, 32'h0, "rd_irq_en");
        rd(32'h14, 32'h0001_0000, "rd_fifo_stat");
        rd(32'h40, 32'h1111_0000, "rd_hdr0");
        rd(32'h44, 32'h2222_0001, "rd_hdr1");
        rd(32'h48, 32'h3333_0002, "rd_hdr2");
        rd(32'h4C, 32'h4444_0003, "rd_hdr3");
        rd(32'h3C, 32'h0, "rd_unmapped_3c");
        rd(32'h18, 32'h0, "rd_unmapped_18");
        rd(32'h50, 32'h0, "rd_unmapped_50");
        rd(32'h1000_0040, 32'h0, "rd_alias_hi");

        // RESETN + START
        bus_write(32'h00, 32'h3);
        chk("ctl_resetn", 32'(resetn_o), 32'h1);
        chk("ctl_start_hi", 32'(start_o), 32'h1);
        @(negedge clk);
        chk("ctl_start_lo", 32'(start_o), 32'h0);
        rd(32'h00, 32'h1, "rd_control_1");

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) bus_write(32'h10, 32'hA0 + i);
        rd(32'h14, 32'h0002_0008, "fifo_full_stat");
        chk("fifo_head_a0", tdata, 32'hA0);
        bus_write(32'h10, 32'hA8);
        rd(32'h08, 32'h100, "ovf_event");
        rd(32'h14, 32'h0002_0008, "ovf_level");
        chk("ovf_head_stable", tdata, 32'hA0);
        bus_write(32'h08, 32'h100);
        rd(32'h08, 32'h0, "ovf_cleared");
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_a_vld", 32'(tvalid), 32'h1);
            chk("drain_a_dat", tdata, 32'hA0 + i);
            @(negedge clk);
        end
        chk("drain_a_empty", 32'(tvalid), 32'h0);
        tready = 1'b0;

        // Push into a full FIFO while popping
        for (int i = 0; i < 8; i++) bus_write(32'h10, 32'hC0 + i);
        tready = 1'b1;
        bus_write(32'h10, 32'hB0);
        tready = 1'b0;
        rd(32'h14, 32'h0002_0008, "pushpop_level");
        rd(32'h08, 32'h0, "pushpop_no_ovf");
        for (int i = 0; i < 7; i++) exp_seq[i] = 32'hC1 + i;
        exp_seq[7] = 32'hB0;
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_b_dat", tdata, exp_seq[i]);
            @(negedge clk);
        end
        chk("drain_b_empty", 32'(tvalid), 32'h0);
        tready = 1'b0;

        // Event capture and irq timing
        bus_write(32'h0C, 32'h001);
        status = 8'h01;
        @(negedge clk);
        rd(32'h08, 32'h001, "evt_rise");
        chk("irq_not_yet", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_hi", 32'(irq), 32'h1);
        status = 8'h00;
        @(negedge clk);
        status = 8'h01;
        bus_write(32'h08, 32'h001);
        rd(32'h08, 32'h001, "evt_set_wins");
        chk("irq_still_hi", 32'(irq), 32'h1);
        bus_write(32'h08, 32'h001);
        rd(32'h08, 32'h000, "evt_w1c");
        chk("irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        chk("irq_lo", 32'(irq), 32'h0);
        status = 8'h00;
        @(negedge clk);

        // Flush via RESETN
        for (int i = 0; i < 5; i++) bus_write(32'h10, 32'hD0 + i);
        rd(32'h14, 32'h0000_0005, "flush_pre");
        bus_write(32'h00, 32'h0);
        chk("flush_tvalid", 32'(tvalid), 32'h0);
        chk("flush_resetn", 32'(resetn_o), 32'h0);
        rd(32'h14, 32'h0001_0000, "flush_stat");
        bus_write(32'h10, 32'hEE);
        rd(32'h14, 32'h0001_0000, "held_stat");
        rd(32'h08, 32'h0, "held_no_ovf");
        chk("held_tvalid", 32'(tvalid), 32'h0);
        bus_write(32'h00, 32'h2);
        chk("start_in_reset", 32'(start_o), 32'h1);
        chk("start_resetn_lo", 32'(resetn_o), 32'h0);
        @(negedge clk);
        chk("start_once", 32'(start_o), 32'h0);

        // Asynchronous reset mid-traffic
        bus_write(32'h00, 32'h1);
        for (int i = 0; i < 3; i++) bus_write(32'h10, 32'hE0 + i);
        bus_write(32'h0C, 32'h1FF);
        status = 8'h80;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_tvalid", 32'(tvalid), 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_resetn", 32'(resetn_o), 32'h0);
        chk("arst_tvalid", 32'(tvalid), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_start", 32'(start_o), 32'h0);
        status = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(32'h14, 32'h0001_0000, "post_rst_fifo");
        rd(32'h08, 32'h0, "post_rst_event");
        rd(32'h0C, 32'h0, "post_rst_irq_en");
        rd(32'h00, 32'h0, "post_rst_control");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
